// File: rtl/hostctrl_cmd_master_if.sv
// hostctrl_cmd_master_if: command/response channels plus the hostCtrl AXI4 bus.
// master modport is the command master's view; slave is the environment's view.
interface hostctrl_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_write;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [1:0]            resp_code;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output resp_valid, resp_write, resp_rdata, resp_code,
    input  resp_ready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    output awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  resp_valid, resp_write, resp_rdata, resp_code,
    output resp_ready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    input  awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/hostctrl_cmd_master.sv
// hostctrl_cmd_master: one-at-a-time single-beat AXI4 register master.
// Optional HOSTCTRL_CMD_MASTER_RSP_CHECK_EN flags bad bid/rid/rlast as SLVERR.
module hostctrl_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] ID_VALUE = '0
) (
  input logic                  clk,
  input logic                  rst,
  hostctrl_cmd_master_if.master bus
);
  localparam logic [2:0] SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    IDLE, WR, WR_B, RD_A, RD_R, RESP
  } state_t;

  state_t state, state_n;

  logic aw_done, aw_done_n;
  logic w_done, w_done_n;
  logic live;
  logic write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [1:0] code_q, code_n;
  logic cmd_ready_q, awvalid_q, wvalid_q;
  logic bready_q, arvalid_q, rready_q, resp_valid_q;
  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, resp_hs;
  logic [1:0] b_code, r_code;

  assign cmd_hs  = bus.cmd_valid & cmd_ready_q;
  assign aw_hs   = awvalid_q & bus.awready;
  assign w_hs    = wvalid_q & bus.wready;
  assign b_hs    = bready_q & bus.bvalid;
  assign ar_hs   = arvalid_q & bus.arready;
  assign r_hs    = rready_q & bus.rvalid;
  assign resp_hs = resp_valid_q & bus.resp_ready;

`ifdef HOSTCTRL_CMD_MASTER_RSP_CHECK_EN
  assign b_code = (bus.bid != ID_VALUE) ? 2'b10 : bus.bresp;
  assign r_code = (bus.rid != ID_VALUE || !bus.rlast) ?
                  2'b10 : bus.rresp;
`else
  logic unused_rsp;
  assign unused_rsp = ^{bus.bid, bus.rid, bus.rlast};
  assign b_code = bus.bresp;
  assign r_code = bus.rresp;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    rdata_n   = rdata_q;
    code_n    = code_q;
    unique case (state)
      IDLE: if (cmd_hs) state_n = bus.cmd_write ? WR : RD_A;
      WR: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if (aw_done_n && w_done_n) begin
          state_n   = WR_B;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      WR_B: if (b_hs) begin
        state_n = RESP;
        code_n  = b_code;
        rdata_n = '0;
      end
      RD_A: if (ar_hs) state_n = RD_R;
      RD_R: if (r_hs) begin
        state_n = RESP;
        code_n  = r_code;
        rdata_n = bus.rdata;
      end
      RESP: if (resp_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every handshake output is registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      live         <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      code_q       <= '0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      aw_done      <= aw_done_n;
      w_done       <= w_done_n;
      live         <= 1'b1;
      rdata_q      <= rdata_n;
      code_q       <= code_n;
      cmd_ready_q  <= state_n == IDLE;
      awvalid_q    <= state_n == WR && !aw_done_n;
      wvalid_q     <= state_n == WR && !w_done_n;
      bready_q     <= state_n == WR_B;
      arvalid_q    <= state_n == RD_A;
      rready_q     <= state_n == RD_R;
      resp_valid_q <= state_n == RESP;
      if (cmd_hs) begin
        write_q <= bus.cmd_write;
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        wstrb_q <= bus.cmd_wstrb;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_write = write_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_code  = code_q;

  // Constant fields read as 0 while in reset.
  assign bus.awid    = live ? ID_VALUE : '0;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = '0;
  assign bus.awsize  = live ? SIZE : '0;
  assign bus.awburst = live ? 2'b01 : 2'b00;
  assign bus.awlock  = 1'b0;
  assign bus.awcache = '0;
  assign bus.awprot  = '0;
  assign bus.awvalid = awvalid_q;

  assign bus.wdata  = wdata_q;
  assign bus.wstrb  = wstrb_q;
  assign bus.wlast  = live;
  assign bus.wvalid = wvalid_q;
  assign bus.bready = bready_q;

  assign bus.arid    = live ? ID_VALUE : '0;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = '0;
  assign bus.arsize  = live ? SIZE : '0;
  assign bus.arburst = live ? 2'b01 : 2'b00;
  assign bus.arlock  = 1'b0;
  assign bus.arcache = '0;
  assign bus.arprot  = '0;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
endmodule

// File: tb/tb_hostctrl_cmd_master.sv
// tb_hostctrl_cmd_master: directed write/read/skew/backpressure/reset vectors.
// Slave side is driven by hand; expected values are hand-computed.
module tb_hostctrl_cmd_master;
`ifdef HOSTCTRL_CMD_MASTER_RSP_CHECK_EN
  localparam logic [1:0] EXP_CK = 2'b10;
`else
  localparam logic [1:0] EXP_CK = 2'b00;
`endif

  logic clk;
  logic rst;
  int n_chk, n_pass;
  int n_aw, n_w, n_b, n_ar, n_resp;
  int aw0, w0, b0, ar0, rsp0;

  hostctrl_cmd_master_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)
  ) bus ();

  hostctrl_cmd_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .ID_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_resp = 0;
  end

  always @(posedge clk) begin
    if (bus.awvalid && bus.awready) n_aw++;
    if (bus.wvalid && bus.wready) n_w++;
    if (bus.bvalid && bus.bready) n_b++;
    if (bus.arvalid && bus.arready) n_ar++;
    if (bus.resp_valid && bus.resp_ready) n_resp++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.resp_ready = 0;
    bus.awready = 0; bus.wready = 0;
    bus.bid = '0; bus.bresp = '0; bus.bvalid = 0;
    bus.arready = 0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
    bus.rlast = 1; bus.rvalid = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_awsize", bus.awsize, 0);
    chk("rst_wlast", bus.wlast, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    rst = 1'b1;
    step();
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_awburst", bus.awburst, 1);

    // zero-wait write
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 16'h0040;
    bus.cmd_wdata = 32'hDEADBEEF; bus.cmd_wstrb = 4'hF;
    bus.awready = 1; bus.wready = 1; bus.bvalid = 1; bus.bresp = 0;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    step();
    bus.cmd_valid = 0;
    chk("wr_awvalid", bus.awvalid, 1);
    chk("wr_wvalid", bus.wvalid, 1);
    chk("wr_awaddr", bus.awaddr, 16'h0040);
    chk("wr_awsize", bus.awsize, 2);
    chk("wr_awlen", bus.awlen, 0);
    chk("wr_wlast", bus.wlast, 1);
    chk("wr_wdata", bus.wdata, 32'hDEADBEEF);
    chk("wr_wstrb", bus.wstrb, 4'hF);
    chk("wr_cmd_ready", bus.cmd_ready, 0);
    chk("wr_bready_early", bus.bready, 0);
    step();
    chk("wr_awvalid_off", bus.awvalid, 0);
    chk("wr_wvalid_off", bus.wvalid, 0);
    chk("wr_bready", bus.bready, 1);
    chk("wr_resp_early", bus.resp_valid, 0);
    step();
    bus.bvalid = 0;
    chk("wr_resp_valid", bus.resp_valid, 1);
    chk("wr_resp_code", bus.resp_code, 0);
    chk("wr_resp_write", bus.resp_write, 1);
    chk("wr_resp_rdata", bus.resp_rdata, 0);
    chk("wr_bready_off", bus.bready, 0);
    bus.resp_ready = 1;
    step();
    bus.resp_ready = 0;
    bus.awready = 0; bus.wready = 0;
    chk("wr_resp_done", bus.resp_valid, 0);
    chk("wr_cmd_ready_back", bus.cmd_ready, 1);
    chk("wr_aw_count", n_aw - aw0, 1);
    chk("wr_w_count", n_w - w0, 1);
    chk("wr_b_count", n_b - b0, 1);

    // read with arready stalled 3 cycles
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 16'h0100;
    ar0 = n_ar;
    step();
    bus.cmd_valid = 0;
    chk("rd_arvalid", bus.arvalid, 1);
    chk("rd_araddr", bus.araddr, 16'h0100);
    chk("rd_arsize", bus.arsize, 2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_arvalid_hold", bus.arvalid, 1);
      chk("rd_araddr_hold", bus.araddr, 16'h0100);
      chk("rd_rready_early", bus.rready, 0);
    end
    bus.arready = 1;
    step();
    bus.arready = 0;
    chk("rd_arvalid_off", bus.arvalid, 0);
    chk("rd_rready", bus.rready, 1);
    chk("rd_ar_count", n_ar - ar0, 1);
    bus.rvalid = 1; bus.rdata = 32'h12345678;
    bus.rresp = 0; bus.rid = 0; bus.rlast = 1;
    step();
    bus.rvalid = 0;
    chk("rd_resp_valid", bus.resp_valid, 1);
    chk("rd_resp_rdata", bus.resp_rdata, 32'h12345678);
    chk("rd_resp_code", bus.resp_code, 0);
    chk("rd_resp_write", bus.resp_write, 0);
    chk("rd_rready_off", bus.rready, 0);

    // response backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_resp_valid", bus.resp_valid, 1);
      chk("bp_resp_rdata", bus.resp_rdata, 32'h12345678);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.resp_ready = 1;
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 16'h0080;
    bus.cmd_wdata = 32'h0BADF00D; bus.cmd_wstrb = 4'h3;
    step();
    bus.resp_ready = 0;
    chk("bp_resp_done", bus.resp_valid, 0);
    chk("bp_cmd_ready_back", bus.cmd_ready, 1);

    // write channel skew
    aw0 = n_aw; w0 = n_w;
    step();
    bus.cmd_valid = 0;
    chk("sk_awvalid", bus.awvalid, 1);
    chk("sk_wvalid", bus.wvalid, 1);
    chk("sk_wstrb", bus.wstrb, 4'h3);
    bus.awready = 1;
    step();
    bus.awready = 0;
    chk("sk_awvalid_drop", bus.awvalid, 0);
    chk("sk_wvalid_hold", bus.wvalid, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sk_wvalid_hold", bus.wvalid, 1);
      chk("sk_wdata_hold", bus.wdata, 32'h0BADF00D);
      chk("sk_awvalid_low", bus.awvalid, 0);
      chk("sk_bready_early", bus.bready, 0);
    end
    bus.wready = 1;
    step();
    bus.wready = 0;
    chk("sk_wvalid_off", bus.wvalid, 0);
    chk("sk_bready", bus.bready, 1);
    chk("sk_aw_count", n_aw - aw0, 1);
    chk("sk_w_count", n_w - w0, 1);
    bus.bvalid = 1; bus.bresp = 2'b10;
    step();
    bus.bvalid = 0; bus.bresp = 0;
    chk("sk_resp_valid", bus.resp_valid, 1);
    chk("sk_resp_code", bus.resp_code, 2'b10);
    chk("sk_resp_rdata", bus.resp_rdata, 0);
    chk("sk_resp_write", bus.resp_write, 1);
    bus.resp_ready = 1;
    step();
    bus.resp_ready = 0;

    // reset while in RD_R
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 16'h0200;
    bus.arready = 1;
    step();
    bus.cmd_valid = 0;
    step();
    bus.arready = 0;
    chk("rs_rready", bus.rready, 1);
    bus.rvalid = 1; bus.rdata = 32'h0000CAFE;
    rst = 1'b0;
    #1;
    chk("rs_rready_off", bus.rready, 0);
    chk("rs_cmd_ready", bus.cmd_ready, 0);
    chk("rs_arvalid", bus.arvalid, 0);
    chk("rs_araddr", bus.araddr, 0);
    chk("rs_arsize", bus.arsize, 0);
    chk("rs_resp_valid", bus.resp_valid, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    bus.rvalid = 0;
    rsp0 = n_resp;
    step();
    chk("rs_cmd_ready_back", bus.cmd_ready, 1);
    bus.resp_ready = 1;
    repeat (3) step();
    bus.resp_ready = 0;
    chk("rs_no_resp_valid", bus.resp_valid, 0);
    chk("rs_no_resp_count", n_resp - rsp0, 0);

    // mismatching rid
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 16'h0010;
    bus.arready = 1;
    step();
    bus.cmd_valid = 0;
    step();
    bus.arready = 0;
    bus.rvalid = 1; bus.rid = 8'h05; bus.rresp = 0;
    bus.rlast = 1; bus.rdata = 32'h000055AA;
    step();
    bus.rvalid = 0; bus.rid = 0;
    chk("ck_resp_valid", bus.resp_valid, 1);
    chk("ck_resp_code", bus.resp_code, EXP_CK);
    chk("ck_resp_rdata", bus.resp_rdata, 32'h000055AA);
    bus.resp_ready = 1;
    step();
    bus.resp_ready = 0;
    chk("ck_cmd_ready", bus.cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
